// File: rtl/fifo_port_arbiter.sv
// Round-robin scheduler sharing one FIFO port between two writers and one reader.
// Optional FIFO_ARB_RD_FIRST_EN gives a non-empty read priority over both writers.
module fifo_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            wr_req,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic                  rd_req,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            wr_gnt,
  output logic [1:0]            wr_rej,
  output logic                  rd_gnt,
  output logic                  rd_rej,
  output logic [2:0]            state,
  output logic [OCC_W-1:0]      occ
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_NO_OP    = 3'b001,
    ST_WRITE    = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_READ     = 3'b100,
    ST_RD_ERROR = 3'b101
  } state_e;

  localparam logic [1:0] REQ_W0 = 2'd0;
  localparam logic [1:0] REQ_RD = 2'd2;

  state_e                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [1:0]            wr_gnt_q, wr_gnt_d;
  logic [1:0]            wr_rej_q, wr_rej_d;
  logic                  rd_gnt_q, rd_gnt_d;
  logic                  rd_rej_q, rd_rej_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [1:0]            ptr_q, ptr_d;

  logic [2:0] elig;
  logic [2:0] sum;
  logic [1:0] cand;
  logic [1:0] win;
  logic       found;
  logic       prio;

  // Winner selection, then the operation it implies
  always_comb begin
    elig  = {rd_req & ~(rd_gnt_q | rd_rej_q), wr_req & ~(wr_gnt_q | wr_rej_q)};
    found = 1'b0;
    prio  = 1'b0;
    win   = REQ_W0;
    sum   = '0;
    cand  = REQ_W0;

    state_d  = ST_NO_OP;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    din_d    = din_q;
    wr_gnt_d = '0;
    wr_rej_d = '0;
    rd_gnt_d = 1'b0;
    rd_rej_d = 1'b0;
    occ_d    = occ_q;
    ptr_d    = ptr_q;

`ifdef FIFO_ARB_RD_FIRST_EN
    // A serviceable read pre-empts the rotation without moving the pointer
    if (elig[2] && (occ_q != '0)) begin
      found = 1'b1;
      prio  = 1'b1;
      win   = REQ_RD;
    end
`endif

    for (int k = 0; k < 3; k++) begin
      sum  = 3'({1'b0, ptr_q}) + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    if (found) begin
      if (!prio) begin
        ptr_d = (win == REQ_RD) ? REQ_W0 : win + 2'd1;
      end
      if (win != REQ_RD) begin
        if (occ_q == OCC_W'(DEPTH)) begin
          wr_rej_d[win[0]] = 1'b1;
          state_d          = ST_WR_ERROR;
        end else begin
          wr_gnt_d[win[0]] = 1'b1;
          wr_en_d          = 1'b1;
          din_d            = win[0] ? din1 : din0;
          occ_d            = occ_q + OCC_W'(1);
          state_d          = ST_WRITE;
        end
      end else begin
        if (occ_q == '0) begin
          rd_rej_d = 1'b1;
          state_d  = ST_RD_ERROR;
        end else begin
          rd_gnt_d = 1'b1;
          rd_en_d  = 1'b1;
          occ_d    = occ_q - OCC_W'(1);
          state_d  = ST_READ;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      din_q    <= '0;
      wr_gnt_q <= '0;
      wr_rej_q <= '0;
      rd_gnt_q <= 1'b0;
      rd_rej_q <= 1'b0;
      occ_q    <= '0;
      ptr_q    <= REQ_W0;
    end else begin
      state_q  <= state_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      din_q    <= din_d;
      wr_gnt_q <= wr_gnt_d;
      wr_rej_q <= wr_rej_d;
      rd_gnt_q <= rd_gnt_d;
      rd_rej_q <= rd_rej_d;
      occ_q    <= occ_d;
      ptr_q    <= ptr_d;
    end
  end

  assign state  = state_q;
  assign wr_en  = wr_en_q;
  assign rd_en  = rd_en_q;
  assign din    = din_q;
  assign wr_gnt = wr_gnt_q;
  assign wr_rej = wr_rej_q;
  assign rd_gnt = rd_gnt_q;
  assign rd_rej = rd_rej_q;
  assign occ    = occ_q;

endmodule
